// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter slice: bus field widths,
// arbiter state encoding, R/W bit values and a round-robin pointer helper.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ST_IDLE      = 3'd0;
   localparam arb_state_t ST_START     = 3'd1;
   localparam arb_state_t ST_WAIT_BUSY = 3'd2;
   localparam arb_state_t ST_WAIT_IDLE = 3'd3;
   localparam arb_state_t ST_DONE      = 3'd4;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Next round-robin position after client idx, wrapping modulo n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   // Normalise a client R/W bit onto the bus encoding.
   function automatic logic is_read(input logic rw);
      return rw == RW_READ;
   endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ. Outputs a one-hot select and its index.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic [IDX_W-1:0]   index
);

   logic             w_found;
   logic [IDX_W-1:0] w_pos;

   // Scan NUM_REQ positions starting at rr_ptr; the first set request wins.
   always_comb begin
      sel     = '0;
      index   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_pos = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!w_found && req[w_pos]) begin
            sel[w_pos] = 1'b1;
            index      = w_pos;
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ clients.
// Latches the winner's addr/data/rw onto the master, pulses enable, waits for
// the master's ready handshake and returns rd_data with a done pulse.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort transactions that run
// for TIMEOUT_CYC cycles (timeout pulse, rd_data = 8'hFF).
module i2c_txn_arbiter import i2c_pkg::*; #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_rw,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      busy,
   output logic                      timeout,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_data_in,
   output logic                      m_rw,
   output logic                      m_enable,
   input  logic [DATA_W-1:0]         m_data_out,
   input  logic                      m_ready
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("i2c_txn_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("i2c_txn_arbiter: TIMEOUT_CYC must fit the 16-bit watchdog");
   end

   arb_state_t         r_state;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_idx;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic               r_busy;
   logic               r_m_enable;
   logic               r_m_rw;
   logic [ADDR_W-1:0]  r_m_addr;
   logic [DATA_W-1:0]  r_m_data;
   logic [DATA_W-1:0]  r_rd_data;

   logic [NUM_REQ-1:0] w_sel;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_ptr_next;
   logic               w_grant;
   logic               w_active;
   logic               w_wdog_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .sel    (w_sel),
      .index  (w_idx)
   );

   assign w_grant    = (r_state == ST_IDLE) && (|req) && m_ready;
   assign w_active   = (r_state == ST_START) || (r_state == ST_WAIT_BUSY) ||
                       (r_state == ST_WAIT_IDLE);
   assign w_ptr_next = IDX_W'(rr_next(32'(r_idx), NUM_REQ));

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int WDOG_W = 16;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout;

   // Hit on the cycle the count would reach TIMEOUT_CYC.
   assign w_wdog_hit = w_active && (r_wdog == WDOG_LAST);

   // Watchdog counter: cleared on grant, counts while a transaction is open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (w_grant) begin
         r_wdog <= '0;
      end else if (w_active) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   // Timeout pulse, aligned with the abort's done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_wdog_hit;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_wdog_hit = 1'b0;
   assign timeout    = 1'b0;
`endif

   // Arbitration FSM: grant, enable handshake, wait for master idle, done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_idx      <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_busy     <= 1'b0;
         r_m_enable <= 1'b0;
         r_m_rw     <= RW_WRITE;
         r_m_addr   <= '0;
         r_m_data   <= '0;
         r_rd_data  <= '0;
      end else begin
         r_done <= '0;
         if (w_wdog_hit) begin
            // Abort skips DONE, so the pointer advances here instead.
            r_done     <= r_gnt;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_m_enable <= 1'b0;
            r_rd_data  <= '1;
            r_rr_ptr   <= w_ptr_next;
            r_state    <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_grant) begin
                     r_idx      <= w_idx;
                     r_gnt      <= w_sel;
                     r_busy     <= 1'b1;
                     r_m_enable <= 1'b1;
                     r_m_addr   <= req_addr[w_idx*ADDR_W +: ADDR_W];
                     r_m_data   <= req_data[w_idx*DATA_W +: DATA_W];
                     r_m_rw     <= is_read(req_rw[w_idx]) ? RW_READ : RW_WRITE;
                     r_state    <= ST_START;
                  end
               end
               ST_START: begin
                  if (!m_ready) begin
                     r_m_enable <= 1'b0;
                     r_state    <= ST_WAIT_BUSY;
                  end
               end
               ST_WAIT_BUSY: begin
                  r_state <= ST_WAIT_IDLE;
               end
               ST_WAIT_IDLE: begin
                  if (m_ready) begin
                     r_rd_data <= m_data_out;
                     r_done    <= r_gnt;
                     r_gnt     <= '0;
                     r_busy    <= 1'b0;
                     r_state   <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  r_rr_ptr <= w_ptr_next;
                  r_state  <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign busy      = r_busy;
   assign rd_data   = r_rd_data;
   assign m_addr    = r_m_addr;
   assign m_data_in = r_m_data;
   assign m_rw      = r_m_rw;
   assign m_enable  = r_m_enable;

endmodule
